intro_qsys_timer_event_logger: RTL

Timestamp logger placed directly downstream of the interval timer's `irq` output. It detects each rising edge of the timer interrupt, records the value of a free-running 32-bit cycle counter into a small FIFO, and exposes the entries to the Nios II over a 16-bit Avalon-MM slave. It raises its own interrupt while entries are pending. Software uses it to measure timer jitter and ISR latency without missing ticks.

---
 rtl/intro_qsys_timer_event_logger.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/intro_qsys_timer_event_logger.sv
// rtl/intro_qsys_timer_event_logger.sv - timer irq edge timestamp logger with Avalon-MM readout
//
// Captures a free-running 32-bit cycle count on every rising edge of the
// interval timer's irq into a DEPTH-entry FIFO. Software drains it over a
// 16-bit Avalon-MM slave.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   irq_in     timer interrupt level, synchronous to clk
//   address    word address (0 STATUS, 1 CONTROL, 2 HEAD_L, 3 HEAD_H,
//              4 DROPS, 5 TS_L, 6 TS_H)
//   chipselect slave select
//   read       read strobe, qualified by chipselect
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data, one cycle latency
//   irq        logger interrupt, high while entries are pending and irq_en

module intro_qsys_timer_event_logger #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [6:0] FULL_LEVEL = 7'(DEPTH);

    logic [31:0]   ts;
    logic [15:0]   ts_shadow;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    level;
    logic          irq_prev;
    logic          enable;
    logic          irq_en;
    logic          overflow;
    logic [15:0]   drops;

    logic          rd_strobe;
    logic          wr_strobe;
    logic          empty;
    logic          full;
    logic          tick;
    logic          flush;
    logic          pop;
    logic          push;
    logic          drop;
    logic [31:0]   head;
    logic [15:0]   rd_mux;

    always_comb begin
        rd_strobe = chipselect & read;
        wr_strobe = chipselect & ~write_n;
        empty     = (level == 7'd0);
        full      = (level == FULL_LEVEL);
        tick      = irq_in & ~irq_prev & enable;
        // Flush wins over any push or pop in the same cycle.
        flush     = wr_strobe & (address == 3'd1) & writedata[2];
        pop       = rd_strobe & (address == 3'd3) & ~empty & ~flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = tick & (~full | pop) & ~flush;
        drop      = tick & full & ~pop & ~flush;
        head      = empty ? 32'h0 : mem[rd_ptr];
    end

    always_comb begin
        rd_mux = 16'h0;
        case (address)
            3'd0:    rd_mux = {overflow, full, empty, 6'b0, level};
            3'd1:    rd_mux = {14'b0, irq_en, enable};
            3'd2:    rd_mux = head[15:0];
            3'd3:    rd_mux = head[31:16];
            3'd4:    rd_mux = drops;
            3'd5:    rd_mux = ts[15:0];
            3'd6:    rd_mux = ts_shadow;
            default: rd_mux = 16'h0;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts        <= 32'h0;
            ts_shadow <= 16'h0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= 7'd0;
            irq_prev  <= 1'b0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            drops     <= 16'h0;
            readdata  <= 16'h0;
            irq       <= 1'b0;
        end else begin
            ts       <= ts + 32'd1;
            irq_prev <= irq_in;
            irq      <= irq_en & ~empty;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= 7'd0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    level <= level + 7'd1;
                end else if (pop && !push) begin
                    level <= level - 7'd1;
                end
            end

            if (wr_strobe && address == 3'd0) begin
                overflow <= 1'b0;
                drops    <= 16'h0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drops != 16'hFFFF) begin
                    drops <= drops + 16'd1;
                end
            end

            if (wr_strobe && address == 3'd1) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end

            if (rd_strobe) begin
                readdata <= rd_mux;
                // Latch the upper half so a later TS_H read pairs with this TS_L.
                if (address == 3'd5) begin
                    ts_shadow <= ts[31:16];
                end
            end
        end
    end

endmodule
